bus_word_receiver: RTL

Parametrised front-end for the instrument's parallel output bus, replacing the separate LDAV glitch filter and fixed-width capture. It synchronises and glitch-filters the raw LDAV strobe, runs the LDAV/LRFD word handshake, and captures DATA_W-bit words into an internal show-ahead FIFO. Downstream consumers, such as the vector/command decoder, drain the FIFO through a valid/ready stream. Sits between the GPIO pins and the display command logic in the clk25 domain.

---
 rtl/bus_word_receiver.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/bus_word_receiver.sv
// Parallel-bus word receiver: LDAV synchroniser and glitch filter, LDAV/LRFD
// word handshake, and a show-ahead FIFO drained through a valid/ready stream.
module bus_word_receiver #(
   parameter int DATA_W     = 15,
   parameter int FILTER_LEN = 16,
   parameter int FIFO_DEPTH = 16,
   parameter int LVL_W      = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              bus_ldav,
   input  logic [DATA_W-1:0] bus_data,
   output logic              bus_lrfd,
   output logic [DATA_W-1:0] word_data,
   output logic              word_valid,
   input  logic              word_ready,
   output logic [LVL_W-1:0]  fifo_level,
   output logic [7:0]        glitch_cnt,
   output logic [1:0]        state_r
);

   localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int FCNT_W = $clog2(FILTER_LEN + 1);
   localparam logic [LVL_W-1:0]  DEPTH_L = LVL_W'(FIFO_DEPTH);
   localparam logic [FCNT_W-1:0] FLAST   = FCNT_W'(FILTER_LEN - 1);

   typedef enum logic [1:0] {
      S_RELEASE = 2'd0,
      S_IDLE    = 2'd1,
      S_ACK     = 2'd2
   } state_t;

   logic              ldav_s1_q, ldav_s1_d, ldav_s2_q, ldav_s2_d;
   logic [DATA_W-1:0] data_s1_q, data_s1_d, data_s2_q, data_s2_d;
   logic              ldav_f_q, ldav_f_d;
   logic [FCNT_W-1:0] fcnt_q, fcnt_d;
   logic [7:0]        glitch_q, glitch_d;
   state_t            state_q, state_d;
   logic              lrfd_q, lrfd_d;
   logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
   logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]  level_q, level_d;
   logic              push, pop;

   always_comb begin
      ldav_s1_d = bus_ldav;
      ldav_s2_d = ldav_s1_q;
      data_s1_d = bus_data;
      data_s2_d = data_s1_q;
      ldav_f_d  = ldav_f_q;
      fcnt_d    = fcnt_q;
      glitch_d  = glitch_q;
      state_d   = state_q;
      lrfd_d    = 1'b0;
      mem_d     = mem_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      level_d   = level_q;

      // A departure from the filtered level that ends short of FILTER_LEN is a glitch.
      if (ldav_s2_q != ldav_f_q) begin
         if (fcnt_q == FLAST) begin
            ldav_f_d = ~ldav_f_q;
            fcnt_d   = '0;
         end else begin
            fcnt_d = fcnt_q + FCNT_W'(1);
         end
      end else begin
         fcnt_d = '0;
         if (fcnt_q != '0 && glitch_q != 8'hFF)
            glitch_d = glitch_q + 8'd1;
      end

      pop  = (level_q != '0) && word_ready;
      push = (state_q == S_IDLE) && ldav_f_q && (level_q != DEPTH_L);

      if (push) begin
         mem_d[wr_ptr_q] = data_s2_q;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop)
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      unique case ({push, pop})
         2'b10:   level_d = level_q + LVL_W'(1);
         2'b01:   level_d = level_q - LVL_W'(1);
         default: level_d = level_q;
      endcase

      // LRFD is only offered while LDAV is filtered low and there is room.
      unique case (state_q)
         S_RELEASE: begin
            if (!ldav_f_q) begin
               state_d = S_IDLE;
               lrfd_d  = (level_d != DEPTH_L);
            end
         end
         S_IDLE: begin
            if (push) state_d = S_ACK;
            lrfd_d = (level_d != DEPTH_L) && !ldav_f_q;
         end
         S_ACK:   state_d = S_RELEASE;
         default: state_d = S_RELEASE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ldav_s1_q <= 1'b1;
         ldav_s2_q <= 1'b1;
         ldav_f_q  <= 1'b1;
         fcnt_q    <= '0;
         glitch_q  <= '0;
         state_q   <= S_RELEASE;
         lrfd_q    <= 1'b0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         level_q   <= '0;
      end else begin
         ldav_s1_q <= ldav_s1_d;
         ldav_s2_q <= ldav_s2_d;
         ldav_f_q  <= ldav_f_d;
         fcnt_q    <= fcnt_d;
         glitch_q  <= glitch_d;
         state_q   <= state_d;
         lrfd_q    <= lrfd_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         level_q   <= level_d;
      end
   end

   // Datapath storage needs no reset; contents are qualified by the level.
   always_ff @(posedge clk) begin
      data_s1_q <= data_s1_d;
      data_s2_q <= data_s2_d;
      mem_q     <= mem_d;
   end

   assign bus_lrfd   = lrfd_q;
   assign word_data  = mem_q[rd_ptr_q];
   assign word_valid = (level_q != '0);
   assign fifo_level = level_q;
   assign glitch_cnt = glitch_q;
   assign state_r    = state_q;

endmodule
